// File: rtl/word_adder_pkg.sv
// Shared definitions for the word adder.
//   WORD      : operand/result width in bits (legal range 8..64).
//   WORD_ZERO : all-zero word, used as the reset value of the registered sum.
// Optional feature macro used by the word_adder files: ADDER_FLAGS_EN.
package word_adder_pkg;

    localparam int unsigned WORD = 32;
    localparam logic [WORD-1:0] WORD_ZERO = '0;

endpackage

// File: rtl/word_adder_if.sv
// Operand/result bundle for word_adder.
//   Ain, Bin   : operands (master -> slave)
//   in_valid   : qualifies Ain/Bin for the registered path (master -> slave)
//   add_out    : combinational sum (slave -> master)
//   add_out_q  : registered sum (slave -> master)
//   out_valid  : add_out_q holds a valid result (slave -> master)
//   carry_out, overflow, zero : combinational flags, present only when
//                               ADDER_FLAGS_EN is defined (slave -> master)
interface word_adder_if;
    import word_adder_pkg::*;

    logic [WORD-1:0] Ain;
    logic [WORD-1:0] Bin;
    logic            in_valid;
    logic [WORD-1:0] add_out;
    logic [WORD-1:0] add_out_q;
    logic            out_valid;
`ifdef ADDER_FLAGS_EN
    logic            carry_out;
    logic            overflow;
    logic            zero;

    modport master (
        output Ain, Bin, in_valid,
        input  add_out, add_out_q, out_valid, carry_out, overflow, zero
    );

    modport slave (
        input  Ain, Bin, in_valid,
        output add_out, add_out_q, out_valid, carry_out, overflow, zero
    );
`else
    modport master (
        output Ain, Bin, in_valid,
        input  add_out, add_out_q, out_valid
    );

    modport slave (
        input  Ain, Bin, in_valid,
        output add_out, add_out_q, out_valid
    );
`endif

endinterface

// File: rtl/word_adder_full_adder_cell.sv
// Single-bit full adder cell (full_adder_cell), one per bit of the ripple chain.
//   a, b : operand bits
//   cin  : carry in from the next-lower bit
//   s    : sum bit
//   cout : carry out to the next-higher bit
module word_adder_full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic p;

    assign p    = a ^ b;
    assign s    = p ^ cin;
    assign cout = (a & b) | (cin & p);

endmodule

// File: rtl/word_adder.sv
// WORD-bit modulo-2^WORD adder for the datapath (PC+4, branch target, address math).
//   clk   : rising-edge clock, registered path only
//   rst_n : asynchronous active-low reset of the registered path
//   bus   : word_adder_if.slave -- Ain/Bin/in_valid in; add_out (combinational),
//           add_out_q/out_valid (one-cycle registered copy) out; with ADDER_FLAGS_EN
//           defined also carry_out/overflow/zero, combinational from Ain/Bin.
// Feature macro: ADDER_FLAGS_EN (undefined: flag ports absent, no flag logic).
module word_adder
    import word_adder_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    word_adder_if.slave   bus
);

    // Ripple-carry chain, carry[0] is the LSB carry-in (always 0).
    logic [WORD:0]   carry;
    logic [WORD-1:0] sum;

    assign carry[0] = 1'b0;

    for (genvar i = 0; i < WORD; i++) begin : g_bit
        word_adder_full_adder_cell u_cell (
            .a    (bus.Ain[i]),
            .b    (bus.Bin[i]),
            .cin  (carry[i]),
            .s    (sum[i]),
            .cout (carry[i+1])
        );
    end

    assign bus.add_out = sum;

`ifdef ADDER_FLAGS_EN
    assign bus.carry_out = carry[WORD];
    // Signed overflow: like-signed operands producing a result of the other sign.
    assign bus.overflow  = (bus.Ain[WORD-1] == bus.Bin[WORD-1]) &&
                           (sum[WORD-1] != bus.Ain[WORD-1]);
    assign bus.zero      = ~|sum;
`else
    // Carry out of the MSB is discarded in this build.
    logic unused_msb_carry;
    assign unused_msb_carry = carry[WORD];
`endif

    // Registered copy: capture on in_valid, otherwise hold the value and drop valid.
    logic [WORD-1:0] sum_d, sum_q;
    logic            valid_d, valid_q;

    always_comb begin
        sum_d   = sum_q;
        valid_d = bus.in_valid;
        if (bus.in_valid) begin
            sum_d = sum;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q   <= WORD_ZERO;
            valid_q <= 1'b0;
        end else begin
            sum_q   <= sum_d;
            valid_q <= valid_d;
        end
    end

    assign bus.add_out_q = sum_q;
    assign bus.out_valid = valid_q;

endmodule

// File: tb/tb_word_adder.sv
// Self-checking bench for word_adder: directed and random operands; the combinational
// result is checked right after each drive, registered results go through a scoreboard
// queue drained by an independent monitor. Builds with or without ADDER_FLAGS_EN.
module tb_word_adder;
    import word_adder_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    word_adder_if bus ();

    word_adder dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    logic [WORD-1:0] exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: plain wide arithmetic, independent of any bit-level structure.
    function automatic logic [WORD-1:0] ref_sum(input logic [WORD-1:0] a, input logic [WORD-1:0] b);
        logic [63:0] full;
        full = 64'(a) + 64'(b);
        return full[WORD-1:0];
    endfunction

    function automatic logic ref_carry(input logic [WORD-1:0] a, input logic [WORD-1:0] b);
        logic [64:0] full;
        full = 65'(a) + 65'(b);
        return full[WORD];
    endfunction

    function automatic logic ref_overflow(input logic [WORD-1:0] a, input logic [WORD-1:0] b);
        longint sa, sb, s, lim;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        s   = sa + sb;
        lim = longint'(1) <<< (WORD - 1);
        return (s > lim - 1) || (s < -lim);
    endfunction

    task automatic check_comb(input logic [WORD-1:0] a, input logic [WORD-1:0] b);
        check("add_out", 64'(bus.add_out), 64'(ref_sum(a, b)));
`ifdef ADDER_FLAGS_EN
        check("carry_out", 64'(bus.carry_out), 64'(ref_carry(a, b)));
        check("overflow", 64'(bus.overflow), 64'(ref_overflow(a, b)));
        check("zero", 64'(bus.zero), 64'(ref_sum(a, b) == WORD_ZERO));
`endif
    endtask

    // Drive one operand pair shortly after a rising edge; a valid pair is expected on
    // add_out_q after the next rising edge.
    task automatic apply(input logic [WORD-1:0] a, input logic [WORD-1:0] b, input logic v);
        @(posedge clk);
        #2;
        bus.Ain      = a;
        bus.Bin      = b;
        bus.in_valid = v;
        #1;
        check_comb(a, b);
        if (v) exp_q.push_back(ref_sum(a, b));
    endtask

    // Monitor: one sample per cycle, 1 time unit after the rising edge.
    logic [WORD-1:0] hold_val = '0;
    logic            exp_valid;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                exp_q.delete();
                hold_val  = WORD_ZERO;
                exp_valid = 1'b0;
            end else if (exp_q.size() != 0) begin
                hold_val  = exp_q.pop_front();
                exp_valid = 1'b1;
            end else begin
                exp_valid = 1'b0;
            end
            check("out_valid", 64'(bus.out_valid), 64'(exp_valid));
            check("add_out_q", 64'(bus.add_out_q), 64'(hold_val));
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    logic [WORD-1:0] ra, rb;
    logic [WORD-1:0] ones;
    logic [WORD-1:0] smax;

    initial begin
        ones = '1;
        smax = {1'b0, {(WORD-1){1'b1}}};
        bus.Ain      = '0;
        bus.Bin      = '0;
        bus.in_valid = 1'b0;

        // Reset held: registered path cleared.
        #3;
        check("rst_add_out_q", 64'(bus.add_out_q), 64'(WORD_ZERO));
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        @(posedge clk);
        @(posedge clk);
        #3;
        rst_n = 1'b1;

        // Directed vectors.
        apply('0, '0, 1'b0);
        apply(WORD'(1), WORD'(1), 1'b0);
        apply(WORD'(4), WORD'(8), 1'b0);
        apply(WORD'(32'hFF00), WORD'(32'h00FF), 1'b0);
        apply({{(WORD/2){1'b1}}, {(WORD/2){1'b0}}}, {{(WORD/2){1'b0}}, {(WORD/2){1'b1}}}, 1'b0);
        apply(ones, WORD'(1), 1'b0);
        apply(smax, WORD'(1), 1'b0);
        apply(WORD'(1), WORD'(0), 1'b0);
        apply(ones, ones, 1'b0);
        apply(~smax, ~smax, 1'b0);

        // Registered path: capture, then hold with valid dropped.
        apply(WORD'(5), WORD'(7), 1'b1);
        apply(WORD'(9), WORD'(9), 1'b0);
        apply(WORD'(3), WORD'(3), 1'b0);

        // Back-to-back throughput.
        for (int i = 0; i < 6; i++) apply(WORD'($urandom), WORD'($urandom), 1'b1);

        // Asynchronous reset between edges with a result valid and another in flight.
        apply(WORD'(100), WORD'(23), 1'b1);
        apply(WORD'(40), WORD'(2), 1'b1);
        #1;
        check("pre_rst_out_valid", 64'(bus.out_valid), 64'd1);
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        check("async_rst_add_out_q", 64'(bus.add_out_q), 64'(WORD_ZERO));
        check("async_rst_out_valid", 64'(bus.out_valid), 64'd0);
        bus.Ain = WORD'(32'h1234);
        bus.Bin = WORD'(32'h0101);
        #1;
        check_comb(WORD'(32'h1234), WORD'(32'h0101));
        @(posedge clk);
        @(posedge clk);
        #3;
        rst_n = 1'b1;

        // Random operands, commutativity and identity.
        for (int i = 0; i < 150; i++) begin
            case ($urandom_range(0, 3))
                0: begin ra = WORD'($urandom); rb = WORD'($urandom); end
                1: begin ra = ones; rb = WORD'($urandom_range(0, 3)); end
                2: begin ra = smax; rb = WORD'($urandom); end
                default: begin ra = WORD'($urandom); rb = '0; end
            endcase
            apply(ra, rb, 1'($urandom_range(0, 1)));
            apply(rb, ra, 1'($urandom_range(0, 1)));
        end

        apply('0, '0, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain: %0d results left, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/word_adder.md
Name: word_adder

Overview:
- 32-bit two's-complement/unsigned integer adder for the MIPS datapath: PC+4, branch-target, and general address arithmetic.
- Provides a zero-latency combinational sum `add_out`, matching the existing datapath usage.
- Also provides a one-cycle registered copy with a valid qualifier, for pipelined consumers.
- Modulo-2^WORD arithmetic; no saturation.

Parameters:
- WORD, 32, operand/result width in bits; comes from the shared `WORD` definition; legal range 8..64.

Ports:
- clk  input  1  rising-edge clock, registered path only.
- rst_n  input  1  asynchronous active-low reset.
- Ain  input  WORD  operand A.
- Bin  input  WORD  operand B.
- in_valid  input  1  qualifies Ain/Bin for the registered path.
- add_out  output  WORD  combinational sum, (Ain + Bin) mod 2^WORD.
- add_out_q  output  WORD  registered sum.
- out_valid  output  1  add_out_q holds a valid result.
- carry_out  output  1  unsigned carry of the combinational sum (ADDER_FLAGS_EN only).
- overflow  output  1  signed overflow of the combinational sum (ADDER_FLAGS_EN only).
- zero  output  1  combinational sum equals 0 (ADDER_FLAGS_EN only).

Behaviour:
- Combinational path:
  - add_out = low WORD bits of Ain + Bin.
  - Purely combinational; same-delta response; no dependence on clk or rst_n.
  - Carry out of the MSB is discarded from add_out.
  - Example: 0xFFFFFFFF + 1 gives 0, with no error indication on add_out.
- Registered path, sampled on each rising clk:
  - If in_valid = 1: add_out_q <= add_out and out_valid <= 1.
  - If in_valid = 0: add_out_q holds its value and out_valid <= 0.
  - Latency is exactly one cycle.
  - Throughput is one result per cycle; no backpressure.
- Reset:
  - rst_n low immediately forces add_out_q = 0 and out_valid = 0, regardless of clk.
  - Release is synchronised by the surrounding reset logic; the first capture happens at the first rising edge with rst_n high.
  - Reset mid-operation discards any in-flight result.
  - add_out and the flags are unaffected by reset.
- Implementation:
  - Ripple-carry chain built from a per-bit full-adder cell.
  - Carry propagates LSB to MSB; operands such as 4+8 and 0xFF00+0x00FF must resolve correctly through the full chain.
  - No X-propagation tricks: X on any operand bit may yield X on the result.
- Boundary results:
  - All-ones result: 0xFFFF0000 + 0x0000FFFF = 0xFFFFFFFF, with carry_out = 0.
  - Identity: A + 0 = A.
  - Commutative: results are identical for swapped operands.

Optional Feature:
- Macro: ADDER_FLAGS_EN.
- Defined:
  - carry_out, overflow and zero ports exist, all combinational from Ain/Bin.
  - carry_out is the bit out of the MSB.
  - overflow = (Ain[MSB] == Bin[MSB]) && (add_out[MSB] != Ain[MSB]).
  - zero = ~|add_out.
- Not defined:
  - The three ports are absent from the port list.
  - No flag logic is synthesised.
  - Sum behaviour is identical in both builds.

Decomposition:
- Shared definitions header/package (definitions.vh) holds:
  - `WORD` (32).
  - A `WORD_ZERO` constant.
  - Nothing else is block-specific.
- One natural sub-module: full_adder_cell (a, b, cin -> s, cout), instantiated WORD times via a generate loop.
- Flag logic and the output register stay in word_adder.

Test Plan:
- Ain=0, Bin=0, then Ain=1, Bin=1 -> add_out=0, then 2; with ADDER_FLAGS_EN, zero=1 then 0.
- Ain=4, Bin=8 -> add_out=12 (carry ripple through low bits); Ain=0xFF00, Bin=0x00FF -> add_out=0x0000FFFF.
- Ain=0xFFFF0000, Bin=0x0000FFFF -> add_out=0xFFFFFFFF, carry_out=0; Ain=0xFFFFFFFF, Bin=1 -> add_out=0, carry_out=1, zero=1, overflow=0.
- Ain=0x7FFFFFFF, Bin=1 -> add_out=0x80000000, overflow=1, carry_out=0; Ain=1, Bin=0 -> add_out=1.
- Registered path:
  - Hold rst_n=0 -> add_out_q=0, out_valid=0.
  - Release rst_n, then drive in_valid=1 with Ain=5, Bin=7 -> next edge gives add_out_q=12, out_valid=1.
  - Drop in_valid -> out_valid=0 next edge, add_out_q stays 12.
- Assert rst_n low between clock edges while out_valid=1 -> add_out_q=0 and out_valid=0 immediately, with no clock edge required; add_out still tracks the operands.
